ula_pipe: RTL
=============

# ula_pipe

Parametrised, handshaked successor to the fixed-width ALU (ULA). It adds a WIDTH generic, valid/ready flow control on input and output, zero and error flags, and an optional multi-cycle shift-add multiplier. The block sits between a UVM-driven operand source and a result consumer. It is the next DUT for the ULA UVM environment.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- i_data_valid  input  1  operand/op offered.
- o_ready  output  1  block accepts the offer this cycle.
- op_selector  input  3  operation code.
- i_data_a, i_data_b  input  WIDTH  operands.
- o_data_valid  output  1  result held and valid.
- i_result_ready  input  1  consumer takes the result.
- o_data_result  output  WIDTH  result (low half for MUL).
- o_data_result_hi  output  WIDTH  high half of MUL product; 0 for other ops.
- o_data_carryout  output  1  carry/borrow/shift-out/overflow flag.
- o_data_zero  output  1  o_data_result == 0 (and hi == 0 for MUL).
- o_op_error  output  1  unsupported op executed.

## Operation
- Acceptance: handshake when i_data_valid && o_ready at a rising edge. Operands and op are latched. Later input changes are ignored until the next acceptance.
- o_ready = (state==IDLE) || (state==DONE && i_result_ready). It is forced to 0 while rst is low.
- Ops:
  - 000 ADD: carry = bit WIDTH of a+b.
  - 001 SUB: a−b mod 2^WIDTH; carry = borrow (a<b).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL by b[SHW-1:0]: carry = last bit shifted out; 0 if amount is 0.
  - 110 SHR (logical): same carry rule as SHL.
  - 111 MUL: unsigned 2·WIDTH-bit product; carry = (hi != 0).
- FSM states IDLE, MUL, DONE:
  - IDLE -accept non-MUL-> DONE, with the result registered at the acceptance edge.
  - IDLE -accept MUL-> MUL. The counter loads WIDTH. Each cycle does one shift-add step and decrements the counter. At counter 1, the next edge goes to DONE.
  - DONE: o_data_valid=1 and all outputs held stable. On i_result_ready, go to IDLE if there is no new acceptance; otherwise the new operation starts exactly as from IDLE (back-to-back).
- Outputs are registered and change only on state entry into DONE or on reset.

## Timing
- Reset (rst low, asynchronous): state IDLE, counter 0, all outputs 0 (o_ready 0). After release, o_ready=1 from the first cycle.
- Non-MUL latency: o_data_valid is high in the cycle after the acceptance edge.
- MUL latency: WIDTH+1 cycles from the acceptance edge to o_data_valid. o_ready=0 throughout.
- Sustained throughput: one op per cycle for non-MUL ops when i_result_ready is held high.
- Backpressure: i_result_ready low in DONE leaves every output frozen indefinitely.
- Reset mid-MUL or in DONE: the operation is discarded immediately and no result is produced.
- i_result_ready outside DONE has no effect.

## Configuration
- ULA_MUL_EN defined: MUL state, counter and accumulator are compiled in; op 111 behaves as above.
- ULA_MUL_EN undefined: no MUL datapath exists. Op 111 completes like a single-cycle op with result=0, hi=0, carry=0, zero=1, o_op_error=1. o_op_error is 0 for all other ops in both builds.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → result 0x00, carry 1, zero 1, o_data_valid one cycle after acceptance.
- SUB 0x10−0x20 → result 0xF0, carry 1, zero 0. SUB 0x20−0x10 → 0x10, carry 0.
- SHL 0x81 by 1 → 0x02, carry 1. SHR 0x81 by 0 → 0x81, carry 0. SHR 0x81 by 1 → 0x40, carry 1.
- ULA_MUL_EN, MUL 0xFF×0xFF → hi 0xFE, lo 0x01, carry 1. Valid 9 cycles after acceptance, o_ready 0 for cycles 1–8. Without ULA_MUL_EN, the same stimulus → result 0, o_op_error 1, valid after 1 cycle.
- Backpressure: hold i_result_ready=0 for 5 cycles after an XOR 0xAA^0x0F → 0xA5 held stable. Then raise i_result_ready with a new AND offered in the same cycle → accepted, and the AND result is valid on the next cycle.
- Assert rst low 3 cycles into a MUL → all outputs 0 at once. After release, ADD 0x03+0x04 → 0x07, carry 0.

Source files
------------

// File: rtl/ula_pipe.sv
// Handshaked ALU with WIDTH-bit operands, zero/error flags and optional shift-add multiplier (ULA_MUL_EN).
// Latency: 1 cycle for non-MUL ops, WIDTH+1 for MUL; results are held while i_result_ready is low.
module ula_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data_valid,
  output logic             o_ready,
  input  logic [2:0]       op_selector,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_data_valid,
  input  logic             i_result_ready,
  output logic [WIDTH-1:0] o_data_result,
  output logic [WIDTH-1:0] o_data_result_hi,
  output logic             o_data_carryout,
  output logic             o_data_zero,
  output logic             o_op_error
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_nx;
  logic   accept;
  logic   mul_go;
  logic   last_step;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_err;
  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
  logic [SHW-1:0]   amt;

  assign amt      = i_data_b[SHW-1:0];
  assign add_full = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign sub_full = {1'b0, i_data_a} - {1'b0, i_data_b};
  assign shl_full = {1'b0, i_data_a} << amt;
  // Shift-out bit lands below the result so a zero shift amount yields carry 0.
  assign shr_full = {i_data_a, 1'b0} >> amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op_selector)
      3'b000: begin alu_res = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; end
      3'b001: begin alu_res = sub_full[WIDTH-1:0]; alu_c = sub_full[WIDTH]; end
      3'b010: alu_res = i_data_a & i_data_b;
      3'b011: alu_res = i_data_a | i_data_b;
      3'b100: alu_res = i_data_a ^ i_data_b;
      3'b101: begin alu_res = shl_full[WIDTH-1:0]; alu_c = shl_full[WIDTH]; end
      3'b110: begin alu_res = shr_full[WIDTH:1];   alu_c = shr_full[0];     end
      default: begin
`ifdef ULA_MUL_EN
        alu_err = 1'b0;
`else
        alu_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef ULA_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH:0]   step_sum;
  logic [2*WIDTH:0] step_shift;
  logic [WIDTH-1:0] nx_hi, nx_lo;

  assign mul_go    = accept && (op_selector == 3'b111);
  assign last_step = (state == MUL) && (cnt == CW'(1));

  // acc_lo starts as the multiplier and drains one bit per step as the product fills in.
  assign step_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mul_b} : '0);
  assign step_shift = {step_sum, acc_lo} >> 1;
  assign nx_hi      = step_shift[2*WIDTH-1:WIDTH];
  assign nx_lo      = step_shift[WIDTH-1:0];
`else
  assign mul_go    = 1'b0;
  assign last_step = 1'b0;
`endif

  // Output process: acceptance control.
  always_comb begin
    o_ready = rst && ((state == IDLE) || ((state == DONE) && i_result_ready));
    accept  = i_data_valid && o_ready;
  end

  // Next-state process.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nx = mul_go ? MUL : DONE;
        else if ((state == DONE) && i_result_ready)
          state_nx = IDLE;
      end
      MUL:     state_nx = last_step ? DONE : MUL;
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      o_data_valid     <= 1'b0;
      o_data_result    <= '0;
      o_data_result_hi <= '0;
      o_data_carryout  <= 1'b0;
      o_data_zero      <= 1'b0;
      o_op_error       <= 1'b0;
`ifdef ULA_MUL_EN
      cnt    <= '0;
      mul_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept && !mul_go) begin
        o_data_valid     <= 1'b1;
        o_data_result    <= alu_res;
        o_data_result_hi <= '0;
        o_data_carryout  <= alu_c;
        o_data_zero      <= (alu_res == '0);
        o_op_error       <= alu_err;
      end else if (accept || ((state == DONE) && i_result_ready)) begin
        o_data_valid <= 1'b0;
      end
`ifdef ULA_MUL_EN
      if (mul_go) begin
        cnt    <= CW'(WIDTH);
        mul_b  <= i_data_b;
        acc_hi <= '0;
        acc_lo <= i_data_a;
      end else if (state == MUL) begin
        cnt    <= cnt - CW'(1);
        acc_hi <= nx_hi;
        acc_lo <= nx_lo;
        if (last_step) begin
          o_data_valid     <= 1'b1;
          o_data_result    <= nx_lo;
          o_data_result_hi <= nx_hi;
          o_data_carryout  <= (nx_hi != '0);
          o_data_zero      <= (nx_hi == '0) && (nx_lo == '0);
          o_op_error       <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
